bcd_serial_add_ctrl: RTL
========================

Name: bcd_serial_add_ctrl

Overview:
- Sequencer that performs a DIGITS-wide packed-BCD addition by time-multiplexing one single-digit BCD adder stage, processing one digit per clock, least-significant digit first.
- Trades latency for area compared with a fully unrolled ripple chain of digit adders.
- Sits between an operand producer and a result consumer.
- Both sides use valid/ready handshakes.

Parameters:
- DIGITS, 4, number of BCD digits per operand. Minimum 1. Operand width is 4*DIGITS.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands A, B, cin are valid
- in_ready  output  1  block can accept an operation
- A  input  4*DIGITS  packed BCD operand; digit k is A[4k+3:4k]
- B  input  4*DIGITS  packed BCD operand
- cin  input  1  carry into digit 0
- out_valid  output  1  sum, cout and err are valid
- out_ready  input  1  consumer accepts the result
- sum  output  4*DIGITS  packed BCD result
- cout  output  1  carry out of the most-significant digit
- err  output  1  at least one input digit of A or B was greater than 9
- busy  output  1  high while in RUN

Behaviour:
- Reset values: in_ready=1, out_valid=0, sum=0, cout=0, err=0, busy=0. State goes to IDLE; internal operand registers, digit index and carry register clear to 0.
- Reset mid-operation aborts the operation with no output, and these values apply immediately (asynchronous).
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On a rising edge with in_valid=1: capture A, B, cin; clear the digit index; clear sum; compute err from all digits (any digit >9); go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle, apply digit index i of the captured A and B, plus the carry register, to the digit stage.
  - On the edge: write the digit result into sum[4i+3:4i], load the carry register with the stage carry, increment i.
  - When i==DIGITS-1, go to DONE on that edge and load cout from the stage carry.
- Digit stage rule (combinational):
  - s = a + b + c, computed 5 bits wide.
  - If s > 9: digit = (s + 6) mod 16, carry = 1. Otherwise digit = s[3:0], carry = 0.
  - The rule applies unchanged to illegal input digits. Results are then not meaningful; err flags them.
- DONE:
  - out_valid=1, in_ready=0.
  - sum, cout and err hold stable while out_ready=0.
  - On an edge with out_ready=1: go to IDLE and clear out_valid.
  - sum, cout and err keep their last values until the next capture.
- Latency: a result is presented exactly DIGITS cycles after the accepting edge. With DIGITS=4: accept at edge 0, out_valid high after edge 4.
- Throughput: one operation per DIGITS+2 cycles at best (no accept in the cycle DONE is left).
- in_valid while not IDLE is ignored. Input ports need not hold after acceptance.
- DIGITS=1: RUN lasts one cycle.
- Digit index counter width is max(1, $clog2(DIGITS)). It never wraps past DIGITS-1.

Decomposition:
- Shared package bcd_pkg:
  - state enum (IDLE, RUN, DONE)
  - BCD_MAX=9
  - BCD_CORR=6
  - digit width constant 4
- One natural sub-module: bcd_digit_stage (combinational; a, b, c in; digit, carry out). Instantiated once.
- The FSM, digit index counter, carry register, operand registers, sum shift/write logic and err detection stay in the top.

Test Plan:
- DIGITS=4, A=0x1234, B=0x5678, cin=0 -> after 4 cycles out_valid=1, sum=0x6912, cout=0, err=0.
- A=0x9999, B=0x0001, cin=0 -> sum=0x0000, cout=1. Also A=0x0000, B=0x0000, cin=1 -> sum=0x0001, cout=0.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid -> sum, cout, err stable. in_valid pulses during that time are ignored and in_ready stays 0. out_ready=1 -> back to IDLE next edge.
- Illegal digit: A=0x000A, B=0x0000 -> err=1, sum=0x0010, cout=0. A following legal operation clears err.
- Assert rst during RUN after 2 digits -> immediately out_valid=0, in_ready=1, sum=0. A new operation 0x0500+0x0500 then yields sum=0x1000.
- Back-to-back: in_valid held high with two operations -> second is accepted only after out_ready handshake completes. Count exactly DIGITS cycles from accept to out_valid for each.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD adder: controller states, BCD constants and a
// digit-legality helper.
package bcd_pkg;

  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned BCD_MAX  = 9;
  localparam int unsigned BCD_CORR = 6;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // High when a 4-bit digit lies outside the BCD range 0..9.
  function automatic logic digit_illegal(input logic [DIGIT_W-1:0] d);
    return d > DIGIT_W'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_stage.sv
// Single-digit BCD adder (combinational).
// Ports:
//   a, b  : input BCD digits
//   c     : carry in
//   digit : BCD sum digit
//   carry : decimal carry out
// Illegal input digits are run through the same rule; the result is then meaningless.
module bcd_digit_stage
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               c,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry
);

  logic [DIGIT_W:0] s;
  logic [DIGIT_W:0] s_corr;

  always_comb begin
    s      = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, c};
    // Max 9+9+1+6 = 25 still fits in five bits.
    s_corr = s + (DIGIT_W + 1)'(BCD_CORR);
    if (s > (DIGIT_W + 1)'(BCD_MAX)) begin
      digit = s_corr[DIGIT_W-1:0];
      carry = 1'b1;
    end else begin
      digit = s[DIGIT_W-1:0];
      carry = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Packed-BCD adder that reuses one digit stage, one digit per clock, LSD first.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid, in_ready  : operand handshake (A, B, cin)
//   A, B, cin           : packed BCD operands and carry into digit 0
//   out_valid, out_ready: result handshake (sum, cout, err)
//   sum, cout           : packed BCD result and carry out of the top digit
//   err                 : some captured operand digit was > 9
//   busy                : high while digits are being processed
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIGIT_W*DIGITS-1:0] A,
  input  logic [DIGIT_W*DIGITS-1:0] B,
  input  logic                      cin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIGIT_W*DIGITS-1:0] sum,
  output logic                      cout,
  output logic                      err,
  output logic                      busy
);

  localparam int unsigned W    = DIGIT_W * DIGITS;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

  state_e            state_q, state_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [W-1:0]      sum_q, sum_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              err_q, err_d;

  logic [DIGIT_W-1:0] a_dig, b_dig, st_digit;
  logic               st_carry;
  logic               any_illegal;

  // Select the current digit of the captured operands.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IdxW'(k)) begin
        a_dig = a_q[DIGIT_W*k +: DIGIT_W];
        b_dig = b_q[DIGIT_W*k +: DIGIT_W];
      end
    end
  end

  bcd_digit_stage u_stage (
    .a     (a_dig),
    .b     (b_dig),
    .c     (carry_q),
    .digit (st_digit),
    .carry (st_carry)
  );

  always_comb begin
    any_illegal = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (digit_illegal(A[DIGIT_W*k +: DIGIT_W]) || digit_illegal(B[DIGIT_W*k +: DIGIT_W])) begin
        any_illegal = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    err_d     = err_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          err_d   = any_illegal;
          state_d = StRun;
        end
      end
      StRun: begin
        busy = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
          if (idx_q == IdxW'(k)) sum_d[DIGIT_W*k +: DIGIT_W] = st_digit;
        end
        carry_d = st_carry;
        if (idx_q == LastIdx) begin
          cout_d  = st_carry;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign err  = err_q;

endmodule
